// File: rtl/pga_pkg.sv
// Shared FSM state type and sizing helpers for the multi-channel PGA writer.
package pga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

    // Bits needed for a channel index; at least one bit for a single channel.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pga_multi_interface_if.sv
// Control-side request/status signals and PGA pin bus of the PGA writer.
interface pga_multi_interface_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 8
);
    logic [N_CH*DATA_W-1:0] code_i;
    logic [N_CH-1:0]        set_i;
    logic                   ready_o;
    logic [N_CH-1:0]        pending_o;
    logic                   done_o;
    logic [N_CH*DATA_W-1:0] cur_code_o;
    logic [N_CH-1:0]        cs_n;
    logic                   sclk;
    logic                   mosi;

    // The writer: takes requests, drives status and the PGA pins.
    modport master (
        input  code_i, set_i,
        output ready_o, pending_o, done_o, cur_code_o, cs_n, sclk, mosi
    );

    // The surroundings: control logic issuing requests, PGAs listening.
    modport slave (
        output code_i, set_i,
        input  ready_o, pending_o, done_o, cur_code_o, cs_n, sclk, mosi
    );
endinterface

// File: rtl/pga_rr_arbiter.sv
// Round-robin grant over per-channel pending requests.
module pga_rr_arbiter
    import pga_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int IDX_W = idx_width(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Search starting at the channel after the last one served; first requester wins.
    always_comb begin
        gnt_o   = {N_CH{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand_s  = {IDX_W{1'b0}};
        for (int i = 1; i <= N_CH; i++) begin
            cand_s = IDX_W'((int'(last_i) + i) % N_CH);
            if (en_i && !found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                gnt_o[cand_s]  = 1'b1;
                idx_o          = cand_s;
            end else begin
            end
        end
    end

endmodule

// File: rtl/pga_multi_interface.sv
// Serialises gain codes to N_CH PGAs over a shared sclk/mosi bus, one cs_n per channel.
module pga_multi_interface
    import pga_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1,
    parameter int CS_GAP   = 2
) (
    input logic                   sck,
    input logic                   rst,
    pga_multi_interface_if.master bus
);

    localparam int IDX_W   = idx_width(N_CH);
    localparam int CNT_MAX = max_of(max_of(CLK_DIV, CS_SETUP), max_of(CS_HOLD, CS_GAP));
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int BIT_W   = cnt_width(DATA_W);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      act_code_q, act_code_d;
    logic [N_CH-1:0]        sel_q, sel_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [N_CH-1:0]        pending_q, pending_d;
    logic [N_CH*DATA_W-1:0] pend_code_q, pend_code_d;
    logic [N_CH*DATA_W-1:0] cur_code_q, cur_code_d;
    logic [N_CH-1:0]        cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;

    logic                   start_s;
    logic                   gnt_en_s;
    logic [N_CH-1:0]        gnt_s;
    logic [IDX_W-1:0]       gnt_idx_s;

    // Grants are only taken when the bus is free: idle, or the last GAP cycle.
    assign gnt_en_s = (state_q == ST_IDLE) ||
                      ((state_q == ST_GAP) && (cnt_q == GAP_LAST));

    pga_rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i  (pending_q),
        .en_i   (gnt_en_s),
        .last_i (last_q),
        .gnt_o  (gnt_s),
        .idx_o  (gnt_idx_s)
    );

    // Frame sequencing, bit shifting and request capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        act_code_d  = act_code_q;
        sel_d       = sel_q;
        last_d      = last_q;
        pending_d   = pending_q;
        pend_code_d = pend_code_q;
        cur_code_d  = cur_code_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        done_d      = 1'b0;
        start_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    start_s = 1'b1;
                end else begin
                    cs_n_d = {N_CH{1'b1}};
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                        sclk_d  = 1'b0;
                    end else begin
                        // New low phase: the only point where mosi moves mid-frame.
                        bit_d   = bit_q + 1'b1;
                        sclk_d  = 1'b0;
                        shift_d = shift_q << 1'b1;
                        mosi_d  = shift_d[DATA_W-1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = {CNT_W{1'b0}};
                    cs_n_d  = {N_CH{1'b1}};
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    for (int k = 0; k < N_CH; k++) begin
                        if (sel_q[k]) begin
                            cur_code_d[k*DATA_W +: DATA_W] = act_code_q;
                        end else begin
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (|pending_q) begin
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                cs_n_d  = {N_CH{1'b1}};
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase

        // Frame start: consume the granted pending code and drop its chip select.
        if (start_s) begin
            state_d = ST_SETUP;
            cnt_d   = {CNT_W{1'b0}};
            bit_d   = {BIT_W{1'b0}};
            sel_d   = gnt_s;
            last_d  = gnt_idx_s;
            cs_n_d  = ~gnt_s;
            sclk_d  = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (gnt_s[k]) begin
                    act_code_d   = pend_code_q[k*DATA_W +: DATA_W];
                    pending_d[k] = 1'b0;
                end else begin
                end
            end
            shift_d = act_code_d;
            mosi_d  = act_code_d[DATA_W-1];
        end else begin
        end

        // Capture after the grant so a set coinciding with its own start re-arms.
        for (int k = 0; k < N_CH; k++) begin
            if (bus.set_i[k]) begin
                pending_d[k]                    = 1'b1;
                pend_code_d[k*DATA_W +: DATA_W] = bus.code_i[k*DATA_W +: DATA_W];
            end else begin
            end
        end

        ready_d = (state_d == ST_IDLE) && (pending_d == {N_CH{1'b0}});
    end

    // Registers; reset releases chip selects and parks sclk at once, aborting any frame.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bit_q       <= {BIT_W{1'b0}};
            shift_q     <= {DATA_W{1'b0}};
            act_code_q  <= {DATA_W{1'b0}};
            sel_q       <= {N_CH{1'b0}};
            last_q      <= IDX_W'(N_CH - 1);
            pending_q   <= {N_CH{1'b0}};
            pend_code_q <= {(N_CH*DATA_W){1'b0}};
            cur_code_q  <= {(N_CH*DATA_W){1'b0}};
            cs_n_q      <= {N_CH{1'b1}};
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            act_code_q  <= act_code_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            pending_q   <= pending_d;
            pend_code_q <= pend_code_d;
            cur_code_q  <= cur_code_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.pending_o  = pending_q;
    assign bus.done_o     = done_q;
    assign bus.cur_code_o = cur_code_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.sclk       = sclk_q;
    assign bus.mosi       = mosi_q;

endmodule

// File: doc/pga_multi_interface.md
Name: pga_multi_interface

Overview:
Parametrised successor to the single-PGA serial writer: drives gain codes to N_CH programmable-gain amplifiers over a shared sclk/mosi bus with one active-low chip select per channel. Each channel has a one-deep pending-code register, so the receiver control logic can request several gain changes back-to-back. A round-robin arbiter serialises the requests, and a programmable divider sets the serial clock rate. The block sits between the AGC/control logic and the PGA pins.

Parameters:
N_CH, 2, number of PGA channels (≥1)
DATA_W, 8, bits per gain code
CLK_DIV, 2, sck cycles per sclk half-period (≥1)
CS_SETUP, 1, sck cycles from cs_n fall to first sclk rise phase (≥1)
CS_HOLD, 1, sck cycles from end of last sclk high phase to cs_n rise (≥1)
CS_GAP, 2, minimum sck cycles with all cs_n high between frames (≥1)

Ports:
sck  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
code_i  in  N_CH*DATA_W  per-channel gain code; slice k = bits [k*DATA_W +: DATA_W]
set_i  in  N_CH  per-channel write request, sampled each cycle
ready_o  out  1  high when FSM is IDLE and no request is pending
pending_o  out  N_CH  request latched for channel k, not yet started
done_o  out  1  one-cycle pulse when a frame completes
cur_code_o  out  N_CH*DATA_W  last code fully shifted to each channel
cs_n  out  N_CH  active-low chip selects
sclk  out  1  serial clock to PGAs, idle low
mosi  out  1  serial data, MSB first

Behaviour:
- Reset values: cs_n all 1, sclk 0, mosi 0, ready_o 1, pending_o 0, done_o 0, cur_code_o 0, arbiter pointer selects channel 0 first.
- Capture: set_i[k]=1 at an edge latches code_i slice k into pend_code[k] and sets pending[k]. A set on an already-pending channel overwrites the code (latest wins). A set on the channel currently shifting latches a new pending request and does not disturb the active frame.
- A set arriving in the same cycle as the frame start for that channel: the start consumes the old pending value, and the new set re-arms pending.
- Arbiter: round-robin over pending[]. It starts searching at the channel after the last one served. It only grants in IDLE, or in the GAP→next transition.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE→SETUP: when any pending bit is set. On entry, latch the granted code into the shift register, clear pending[g], drive cs_n[g]=0 and mosi=MSB.
- SETUP: lasts CS_SETUP cycles with sclk=0.
- SHIFT: DATA_W bits. Each bit has sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. mosi updates only at the start of each low phase; slaves sample on the sclk rise.
- HOLD: lasts CS_HOLD cycles with sclk=0 and cs_n[g] still low.
- HOLD→GAP: cs_n[g]=1, done_o pulses for 1 cycle, cur_code_o slice g updated.
- GAP: lasts CS_GAP cycles. Then go to SETUP if any request is pending, else IDLE.
- Frame length = CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD cycles with cs_n low, followed by CS_GAP cycles high.
- Latency from IDLE: with set_i high at edge 0, cs_n[k] is low after edge 1.
- ready_o is low from the edge after set_i until return to IDLE with pending all 0.
- At most one cs_n bit is low at any time. mosi is 0 whenever all cs_n are high.
- rst asserted mid-frame: cs_n returns to 1 and sclk to 0 immediately (async). The frame is aborted and pending is cleared. cur_code_o is reset to 0.
- Counters are sized by $clog2 of their maximum value plus 1. No wrap occurs within a frame.

Decomposition:
- pga_pkg: FSM state enum and the localparam helper functions for counter widths.
- Sub-module pga_rr_arbiter: round-robin, N_CH-wide. Inputs are req vector, grant enable and last-grant pointer. Output is one-hot grant plus index.

Test Plan:
- Defaults, set_i=2'b01, code 0x8F → cs_n[0] low for 1+32+1 = 34 cycles. Bits 1000_1111 are sampled on the sclk rises, done_o pulses once, cur_code_o[7:0]=0x8F, ready_o returns 1.
- set_i=2'b11 in the same cycle with codes 0x12 (ch0) and 0x34 (ch1) → ch0 frame, then ≥2 cycles with all cs_n high, then ch1 frame. done_o pulses twice; cs_n are never low together.
- ch1 set 0xAA, then 0x55 while ch0 is shifting (ch1 still pending) → ch1 receives only 0x55.
- During the ch0 frame sending 0x01, set ch0 to 0xF0 → the first frame completes with 0x01, then a second ch0 frame sends 0xF0.
- rst pulse halfway through SHIFT → cs_n=all 1 and sclk=0 asynchronously, pending_o=0, done_o never pulses, ready_o=1 after release.
- N_CH=4, DATA_W=16, CLK_DIV=1 → 0xBEEF on ch3 gives 16 sclk periods of 2 cycles each and cur_code_o slice 3 = 0xBEEF.
